inst_executor: RTL and testbench
================================

INST_EXECUTOR -- requirements
Module: inst_executor

Interface
REQ-001 SHALL have port clk_in, input, 1: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_in, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have ports inst_in (input, DECODED_INSTRUCTION_WIDTH, DecodedInst), inst_valid_in (input, 1) and inst_ready_out (output, 1); an instruction is accepted on any edge where valid and ready are both high.
REQ-004 SHALL have port camera_out, output, CAMERA_WIDTH: current Camera record.
REQ-005 SHALL have light RAM ports light_addr_out (LightAddr), light_we_out (1), light_wdata_out (LIGHT_WIDTH) as outputs and light_rdata_in (LIGHT_WIDTH) as input.
REQ-006 SHALL have geometry RAM ports geom_addr_out (GeometryAddr), geom_we_out (1), geom_wdata_out (GEOMETRY_WIDTH) as outputs and geom_rdata_in (GEOMETRY_WIDTH) as input.
REQ-007 SHALL have outputs render_start_out, frame_out, loop_out and err_out (1-cycle pulses), halted_out (level), and input render_done_in (1-cycle pulse).

Function
REQ-008 SHALL consume DecodedInst records: apply (prop, data), then (prop2, data2) only if prop2 != 0; unknown property codes leave fields unchanged.
REQ-009 SHALL hold inst_ready_out high only in IDLE.
REQ-010 SHALL use states IDLE, RD, WAIT, WR, RENDER_WAIT, HALT.
REQ-011 SHALL, for opCameraSet accepted at cycle N, update camera_out from CameraProperty at N+1 and stay in IDLE (1 instr/cycle).
REQ-012 SHALL, for opLightSet accepted at cycle N, drive light_addr_out=lIndex at N+1 (RD), wait for 2-cycle RAM latency (WAIT), pulse light_we_out with the merged record at N+3 (WR), and return to IDLE at N+4.
REQ-013 SHALL merge light fields so lpType sets lType=data[1:0], lpColor sets col=data, and the remaining LightProperty codes set the matching float16 field.
REQ-014 SHALL use the same RD/WAIT/WR sequence on geometry RAM for opShapeSet (ShapeProperty map, raytracing mode) and opShapeData (TriangleProperty map, rasterization mode), with mat=data[1:0] and col=data.
REQ-015 SHALL drop an opShapeSet/opShapeData whose map mismatches RENDERING_MODE and pulse err_out.
REQ-016 SHALL, for opShapeInit accepted at N, write at N+1 without reading: raytracing gives sType=inst sType with all other fields 0, rasterization gives an all-zero Triangle; IDLE at N+2.
REQ-017 SHALL drop with an err_out pulse, and without any RAM access, any lIndex >= NUM_LIGHTS or sIndex >= GEOMETRY_DEPTH.
REQ-018 SHALL, for opRender, pulse render_start_out at N+1, hold RENDER_WAIT until render_done_in, and return to IDLE the following cycle; render_done_in arriving outside RENDER_WAIT is ignored.
REQ-019 SHALL, for opFrame or opLoop, pulse frame_out or loop_out at N+1 and remain in IDLE.
REQ-020 SHALL, for opEnd, enter HALT with halted_out=1 and ready low until reset; SHALL pulse err_out and drop opUnsupported.
REQ-021 SHALL keep *_we_out low outside WR or the ShapeInit write cycle, and SHALL hold addresses stable from RD through WR.

Reset
REQ-022 SHALL, while rst_in is high, immediately force state=IDLE, camera_out=0, halted_out=0, and all pulses, we, addr and wdata outputs to 0.
REQ-023 SHALL abandon any in-flight read-modify-write on reset assertion with no write issued; RAM contents are untouched.
REQ-024 SHALL assert inst_ready_out=1 on the first edge after reset release.

Structure
REQ-025 SHALL put the ExecState enum and BRAM_READ_LATENCY=2 in package proctypes.
REQ-026 SHALL place field merging in the combinational sub-module geom_prop_merge, one per RENDERING_MODE map; light merging stays inline.

Verification
REQ-027 SHALL cover: opCameraSet prop=cpXLocation data=16'h3C00, prop2=cpFovHor data2=16'h4000 -> camera_out.xloc=3C00, hfov=4000 next cycle, ready stays high.
REQ-028 SHALL cover: opLightSet lIndex=3, lpColor=16'hF800, prop2=0 -> addr=3 at N+1, single we at N+3 with col=F800 and other fields equal rdata, ready at N+4.
REQ-029 SHALL cover: opLightSet lIndex=9 -> err_out pulse, no we, ready next cycle.
REQ-030 SHALL cover: opShapeData sIndex=5, tpX1=16'h3C00 (raster mode) -> geom we at N+3, x1=3C00; sIndex=2000 -> err_out.
REQ-031 SHALL cover: opRender, then render_done_in after 10 cycles -> ready low for 10 cycles and high 1 cycle after done; then opEnd -> halted_out=1, ready low.
REQ-032 SHALL cover: rst_in asserted during WAIT of a light RMW -> no light_we_out pulse, all outputs 0, ready=1 after release.

Source files
------------

// File: rtl/proctypes_pkg.sv
// Shared types for the instruction executor.
// Contents: executor FSM states, RAM read latency, opcode and property encodings,
// the Camera / Light / Shape / Triangle records, and the DecodedInst record.
package proctypes;

    localparam int unsigned BRAM_READ_LATENCY = 2;

    typedef logic [7:0]  LightIndex;
    typedef logic [15:0] ShapeIndex;
    typedef logic [2:0]  LightAddr;
    typedef logic [9:0]  GeometryAddr;

    localparam LightIndex NUM_LIGHTS     = 8'd8;
    localparam ShapeIndex GEOMETRY_DEPTH = 16'd1024;

    typedef enum logic {MODE_RAYTRACE = 1'b0, MODE_RASTER = 1'b1} RenderMode;
    localparam RenderMode RENDERING_MODE = MODE_RASTER;

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RENDER_WAIT, HALT} ExecState;

    typedef enum logic [3:0] {
        opCameraSet   = 4'd0,
        opLightSet    = 4'd1,
        opShapeInit   = 4'd2,
        opShapeSet    = 4'd3,
        opShapeData   = 4'd4,
        opRender      = 4'd5,
        opFrame       = 4'd6,
        opLoop        = 4'd7,
        opEnd         = 4'd8,
        opUnsupported = 4'd9
    } OpCode;

    typedef enum logic [3:0] {
        cpNone = 4'd0, cpXLocation, cpYLocation, cpZLocation, cpFovHor, cpFovVer
    } CameraProperty;

    typedef enum logic [3:0] {
        lpNone = 4'd0, lpType, lpColor, lpXLocation, lpYLocation, lpZLocation, lpIntensity
    } LightProperty;

    typedef enum logic [3:0] {
        spNone = 4'd0, spMat, spColor, spXLocation, spYLocation, spZLocation, spRadius
    } ShapeProperty;

    typedef enum logic [3:0] {
        tpNone = 4'd0, tpMat, tpColor, tpX1, tpY1, tpX2, tpY2, tpX3, tpY3
    } TriangleProperty;

    typedef struct packed {
        logic [15:0] xloc;
        logic [15:0] yloc;
        logic [15:0] zloc;
        logic [15:0] hfov;
        logic [15:0] vfov;
    } Camera;

    typedef struct packed {
        logic [1:0]  lType;
        logic [15:0] col;
        logic [15:0] xloc;
        logic [15:0] yloc;
        logic [15:0] zloc;
        logic [15:0] intensity;
    } Light;

    // Shape is padded so both geometry records share one RAM word width.
    typedef struct packed {
        logic [29:0] pad;
        logic [1:0]  sType;
        logic [1:0]  mat;
        logic [15:0] col;
        logic [15:0] xloc;
        logic [15:0] yloc;
        logic [15:0] zloc;
        logic [15:0] radius;
    } Shape;

    typedef struct packed {
        logic [1:0]  mat;
        logic [15:0] col;
        logic [15:0] x1;
        logic [15:0] y1;
        logic [15:0] x2;
        logic [15:0] y2;
        logic [15:0] x3;
        logic [15:0] y3;
    } Triangle;

    typedef struct packed {
        OpCode       op;
        LightIndex   lIndex;
        ShapeIndex   sIndex;
        logic [1:0]  sType;
        logic [3:0]  prop;
        logic [15:0] data;
        logic [3:0]  prop2;
        logic [15:0] data2;
    } DecodedInst;

    localparam int unsigned CAMERA_WIDTH              = $bits(Camera);
    localparam int unsigned LIGHT_WIDTH               = $bits(Light);
    localparam int unsigned GEOMETRY_WIDTH            = $bits(Triangle);
    localparam int unsigned DECODED_INSTRUCTION_WIDTH = $bits(DecodedInst);

    // Unknown property codes return the record unchanged.
    function automatic Camera camera_apply(input Camera c, input logic [3:0] prop,
                                           input logic [15:0] data);
        Camera r;
        r = c;
        case (prop)
            cpXLocation: r.xloc = data;
            cpYLocation: r.yloc = data;
            cpZLocation: r.zloc = data;
            cpFovHor:    r.hfov = data;
            cpFovVer:    r.vfov = data;
            default:     ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/geom_prop_merge.sv
// Combinational merge of up to two property updates into a geometry record.
// MODE selects the property map: ShapeProperty (raytracing) or TriangleProperty
// (rasterization). The second update is applied only when i_prop2 is non-zero.
// Ports:
//   i_rec            record read from geometry RAM
//   i_prop / i_data  first property update
//   i_prop2/ i_data2 optional second property update
//   o_rec            merged record
module geom_prop_merge
    import proctypes::*;
#(
    parameter RenderMode MODE = RENDERING_MODE
) (
    input  logic [GEOMETRY_WIDTH-1:0] i_rec,
    input  logic [3:0]                i_prop,
    input  logic [15:0]               i_data,
    input  logic [3:0]                i_prop2,
    input  logic [15:0]               i_data2,
    output logic [GEOMETRY_WIDTH-1:0] o_rec
);

    function automatic logic [GEOMETRY_WIDTH-1:0] apply_prop(
        input logic [GEOMETRY_WIDTH-1:0] rec,
        input logic [3:0]                prop,
        input logic [15:0]               data
    );
        Shape    s;
        Triangle t;
        s = rec;
        t = rec;
        if (MODE == MODE_RAYTRACE) begin
            case (prop)
                spMat:       s.mat    = data[1:0];
                spColor:     s.col    = data;
                spXLocation: s.xloc   = data;
                spYLocation: s.yloc   = data;
                spZLocation: s.zloc   = data;
                spRadius:    s.radius = data;
                default:     ;
            endcase
            return s;
        end else begin
            case (prop)
                tpMat:   t.mat = data[1:0];
                tpColor: t.col = data;
                tpX1:    t.x1  = data;
                tpY1:    t.y1  = data;
                tpX2:    t.x2  = data;
                tpY2:    t.y2  = data;
                tpX3:    t.x3  = data;
                tpY3:    t.y3  = data;
                default: ;
            endcase
            return t;
        end
    endfunction

    always_comb begin
        o_rec = apply_prop(i_rec, i_prop, i_data);
        if (i_prop2 != 4'd0) begin
            o_rec = apply_prop(o_rec, i_prop2, i_data2);
        end
    end

endmodule

// File: rtl/inst_executor.sv
// Executes decoded scene instructions: camera updates in place, light and
// geometry updates as read-modify-write against external RAMs, and render /
// frame / loop / end control.
// Ports:
//   clk_in, rst_in                 clock, async active-high reset
//   inst_in/inst_valid_in/ready    instruction handshake (ready only in IDLE)
//   camera_out                     current camera record
//   light_*                        light RAM (BRAM_READ_LATENCY read latency)
//   geom_*                         geometry RAM (BRAM_READ_LATENCY read latency)
//   render_start_out, frame_out,
//   loop_out, err_out              1-cycle pulses
//   halted_out                     level, set by opEnd until reset
//   render_done_in                 1-cycle pulse ending RENDER_WAIT
module inst_executor
    import proctypes::*;
(
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  DecodedInst                inst_in,
    input  logic                      inst_valid_in,
    output logic                      inst_ready_out,
    output Camera                     camera_out,
    output LightAddr                  light_addr_out,
    output logic                      light_we_out,
    output logic [LIGHT_WIDTH-1:0]    light_wdata_out,
    input  logic [LIGHT_WIDTH-1:0]    light_rdata_in,
    output GeometryAddr               geom_addr_out,
    output logic                      geom_we_out,
    output logic [GEOMETRY_WIDTH-1:0] geom_wdata_out,
    input  logic [GEOMETRY_WIDTH-1:0] geom_rdata_in,
    output logic                      render_start_out,
    output logic                      frame_out,
    output logic                      loop_out,
    output logic                      err_out,
    output logic                      halted_out,
    input  logic                      render_done_in
);

    // WAIT lasts BRAM_READ_LATENCY-1 cycles; RD supplies the first latency cycle.
    localparam logic [1:0] WAIT_LAST = 2'(BRAM_READ_LATENCY - 2);

    ExecState    r_state, w_state_next;
    Camera       r_camera, w_camera;
    LightAddr    r_light_addr;
    GeometryAddr r_geom_addr;
    logic [1:0]  r_wait_cnt;
    logic [3:0]  r_prop, r_prop2;
    logic [15:0] r_data, r_data2;
    logic [1:0]  r_stype;
    logic        r_is_light, w_is_light;
    logic        r_init, w_init;
    logic        w_load;
    logic        r_render_start, w_render_start;
    logic        r_frame, w_frame;
    logic        r_loop, w_loop;
    logic        r_err, w_err;
    logic        w_light_ok, w_geom_ok;
    Light        w_light_merged;
    Shape        w_shape_init;
    logic [GEOMETRY_WIDTH-1:0] w_geom_merged, w_geom_init;

    function automatic Light light_apply(input Light l, input logic [3:0] prop,
                                         input logic [15:0] data);
        Light r;
        r = l;
        case (prop)
            lpType:      r.lType     = data[1:0];
            lpColor:     r.col       = data;
            lpXLocation: r.xloc      = data;
            lpYLocation: r.yloc      = data;
            lpZLocation: r.zloc      = data;
            lpIntensity: r.intensity = data;
            default:     ;
        endcase
        return r;
    endfunction

    assign w_light_ok = (inst_in.lIndex < NUM_LIGHTS);
    assign w_geom_ok  = (inst_in.sIndex < GEOMETRY_DEPTH);

    // Next-state and accept-time decode.
    always_comb begin
        w_state_next   = r_state;
        w_camera       = r_camera;
        w_is_light     = r_is_light;
        w_init         = r_init;
        w_load         = 1'b0;
        w_render_start = 1'b0;
        w_frame        = 1'b0;
        w_loop         = 1'b0;
        w_err          = 1'b0;
        case (r_state)
            IDLE: begin
                if (inst_valid_in) begin
                    case (inst_in.op)
                        opCameraSet: begin
                            w_camera = camera_apply(r_camera, inst_in.prop, inst_in.data);
                            if (inst_in.prop2 != 4'd0) begin
                                w_camera = camera_apply(w_camera, inst_in.prop2, inst_in.data2);
                            end
                        end
                        opLightSet: begin
                            if (w_light_ok) begin
                                w_load       = 1'b1;
                                w_is_light   = 1'b1;
                                w_init       = 1'b0;
                                w_state_next = RD;
                            end else begin
                                w_err = 1'b1;
                            end
                        end
                        opShapeSet, opShapeData: begin
                            // Each opcode carries one property map; it must match the build mode.
                            if (w_geom_ok && ((inst_in.op == opShapeSet) ==
                                              (RENDERING_MODE == MODE_RAYTRACE))) begin
                                w_load       = 1'b1;
                                w_is_light   = 1'b0;
                                w_init       = 1'b0;
                                w_state_next = RD;
                            end else begin
                                w_err = 1'b1;
                            end
                        end
                        opShapeInit: begin
                            if (w_geom_ok) begin
                                w_load       = 1'b1;
                                w_is_light   = 1'b0;
                                w_init       = 1'b1;
                                w_state_next = WR;
                            end else begin
                                w_err = 1'b1;
                            end
                        end
                        opRender: begin
                            w_render_start = 1'b1;
                            w_state_next   = RENDER_WAIT;
                        end
                        opFrame: w_frame = 1'b1;
                        opLoop:  w_loop  = 1'b1;
                        opEnd:   w_state_next = HALT;
                        default: w_err = 1'b1;
                    endcase
                end
            end
            RD:   w_state_next = WAIT;
            WAIT: begin
                if (r_wait_cnt == WAIT_LAST) begin
                    w_state_next = WR;
                end
            end
            WR:   w_state_next = IDLE;
            RENDER_WAIT: begin
                if (render_done_in) begin
                    w_state_next = IDLE;
                end
            end
            HALT:    w_state_next = HALT;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state        <= IDLE;
            r_camera       <= '0;
            r_light_addr   <= '0;
            r_geom_addr    <= '0;
            r_wait_cnt     <= '0;
            r_prop         <= '0;
            r_data         <= '0;
            r_prop2        <= '0;
            r_data2        <= '0;
            r_stype        <= '0;
            r_is_light     <= 1'b0;
            r_init         <= 1'b0;
            r_render_start <= 1'b0;
            r_frame        <= 1'b0;
            r_loop         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_camera       <= w_camera;
            r_render_start <= w_render_start;
            r_frame        <= w_frame;
            r_loop         <= w_loop;
            r_err          <= w_err;
            r_wait_cnt     <= (r_state == WAIT) ? r_wait_cnt + 2'd1 : 2'd0;
            if (w_load) begin
                r_prop     <= inst_in.prop;
                r_data     <= inst_in.data;
                r_prop2    <= inst_in.prop2;
                r_data2    <= inst_in.data2;
                r_stype    <= inst_in.sType;
                r_is_light <= w_is_light;
                r_init     <= w_init;
                if (w_is_light) begin
                    r_light_addr <= inst_in.lIndex[2:0];
                end else begin
                    r_geom_addr <= inst_in.sIndex[9:0];
                end
            end
        end
    end

    geom_prop_merge #(
        .MODE (RENDERING_MODE)
    ) u_geom_merge (
        .i_rec   (geom_rdata_in),
        .i_prop  (r_prop),
        .i_data  (r_data),
        .i_prop2 (r_prop2),
        .i_data2 (r_data2),
        .o_rec   (w_geom_merged)
    );

    always_comb begin
        w_light_merged = light_apply(Light'(light_rdata_in), r_prop, r_data);
        if (r_prop2 != 4'd0) begin
            w_light_merged = light_apply(w_light_merged, r_prop2, r_data2);
        end
    end

    always_comb begin
        w_shape_init       = '0;
        w_shape_init.sType = r_stype;
        if (RENDERING_MODE == MODE_RAYTRACE) begin
            w_geom_init = w_shape_init;
        end else begin
            w_geom_init = '0;
        end
    end

    // Write data is gated by the strobe so the buses stay at zero when idle.
    always_comb begin
        inst_ready_out   = (r_state == IDLE);
        halted_out       = (r_state == HALT);
        camera_out       = r_camera;
        light_addr_out   = r_light_addr;
        geom_addr_out    = r_geom_addr;
        light_we_out     = (r_state == WR) && r_is_light;
        geom_we_out      = (r_state == WR) && !r_is_light;
        light_wdata_out  = light_we_out ? w_light_merged : '0;
        geom_wdata_out   = '0;
        if (geom_we_out) begin
            geom_wdata_out = r_init ? w_geom_init : w_geom_merged;
        end
        render_start_out = r_render_start;
        frame_out        = r_frame;
        loop_out         = r_loop;
        err_out          = r_err;
    end

endmodule

// File: tb/tb_inst_executor.sv
module tb_inst_executor;
    import proctypes::*;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    DecodedInst  inst_in = '0;
    logic        inst_valid_in = 1'b0;
    logic        inst_ready_out;
    Camera       camera_out;
    LightAddr    light_addr_out;
    logic        light_we_out;
    Light        light_wdata_out;
    Light        light_rdata_in;
    GeometryAddr geom_addr_out;
    logic        geom_we_out;
    Triangle     geom_wdata_out;
    Triangle     geom_rdata_in;
    logic        render_start_out, frame_out, loop_out, err_out, halted_out;
    logic        render_done_in = 1'b0;

    int n_pass = 0;
    int n_total = 0;
    int light_we_cnt = 0;
    int geom_we_cnt = 0;

    // RAM models with two-cycle read latency and a bench-side preload port.
    Light        light_mem [8];
    Light        light_pipe;
    Triangle     geom_mem [1024];
    Triangle     geom_pipe;
    logic        pre_l_we = 1'b0;
    LightAddr    pre_l_addr = '0;
    Light        pre_l_data = '0;
    logic        pre_g_we = 1'b0;
    GeometryAddr pre_g_addr = '0;
    Triangle     pre_g_data = '0;

    always #5 clk_in = ~clk_in;

    inst_executor u_dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .inst_in          (inst_in),
        .inst_valid_in    (inst_valid_in),
        .inst_ready_out   (inst_ready_out),
        .camera_out       (camera_out),
        .light_addr_out   (light_addr_out),
        .light_we_out     (light_we_out),
        .light_wdata_out  (light_wdata_out),
        .light_rdata_in   (light_rdata_in),
        .geom_addr_out    (geom_addr_out),
        .geom_we_out      (geom_we_out),
        .geom_wdata_out   (geom_wdata_out),
        .geom_rdata_in    (geom_rdata_in),
        .render_start_out (render_start_out),
        .frame_out        (frame_out),
        .loop_out         (loop_out),
        .err_out          (err_out),
        .halted_out       (halted_out),
        .render_done_in   (render_done_in)
    );

    always @(posedge clk_in) begin
        if (pre_l_we) light_mem[pre_l_addr] <= pre_l_data;
        else if (light_we_out) light_mem[light_addr_out] <= light_wdata_out;
        light_pipe     <= light_mem[light_addr_out];
        light_rdata_in <= light_pipe;
        if (light_we_out) light_we_cnt <= light_we_cnt + 1;
        if (pre_g_we) geom_mem[pre_g_addr] <= pre_g_data;
        else if (geom_we_out) geom_mem[geom_addr_out] <= geom_wdata_out;
        geom_pipe     <= geom_mem[geom_addr_out];
        geom_rdata_in <= geom_pipe;
        if (geom_we_out) geom_we_cnt <= geom_we_cnt + 1;
    end

    function automatic DecodedInst mk(input OpCode op, input LightIndex li, input ShapeIndex si,
                                      input logic [3:0] p, input logic [15:0] d,
                                      input logic [3:0] p2, input logic [15:0] d2);
        DecodedInst i;
        i.op = op; i.lIndex = li; i.sIndex = si; i.sType = 2'd0;
        i.prop = p; i.data = d; i.prop2 = p2; i.data2 = d2;
        return i;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Presents one instruction for one edge; returns in the cycle after acceptance.
    task automatic send(input DecodedInst i);
        inst_in = i;
        inst_valid_in = 1'b1;
        tick();
        inst_valid_in = 1'b0;
    endtask

    task automatic preload_light(input LightAddr a, input Light d);
        pre_l_addr = a; pre_l_data = d; pre_l_we = 1'b1;
        tick();
        pre_l_we = 1'b0;
    endtask

    task automatic preload_geom(input GeometryAddr a, input Triangle d);
        pre_g_addr = a; pre_g_data = d; pre_g_we = 1'b1;
        tick();
        pre_g_we = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_total++;
        if (camera_out !== '0 || halted_out !== 1'b0)
            $display("FAIL reset_state: camera=%h halted=%b, want 0 0", camera_out, halted_out);
        else n_pass++;
        n_total++;
        if ({light_we_out, geom_we_out, render_start_out, frame_out, loop_out, err_out} !== 6'b0
            || light_addr_out !== '0 || geom_addr_out !== '0)
            $display("FAIL reset_outputs: we/pulses=%b%b%b%b%b%b la=%h ga=%h, want 0",
                     light_we_out, geom_we_out, render_start_out, frame_out, loop_out, err_out,
                     light_addr_out, geom_addr_out);
        else n_pass++;
        rst_in = 1'b0;
        tick();
        n_total++;
        if (inst_ready_out !== 1'b1)
            $display("FAIL reset_ready: got %b want 1", inst_ready_out);
        else n_pass++;
    endtask

    task automatic test_camera();
        Camera exp;
        exp = '0; exp.xloc = 16'h3C00; exp.hfov = 16'h4000;
        send(mk(opCameraSet, 8'd0, 16'd0, cpXLocation, 16'h3C00, cpFovHor, 16'h4000));
        n_total++;
        if (camera_out !== exp || inst_ready_out !== 1'b1)
            $display("FAIL camera_set: camera=%h ready=%b, want %h 1", camera_out, inst_ready_out, exp);
        else n_pass++;
        // Unknown prop code and a zero prop2 with junk data2 both leave the camera alone.
        send(mk(opCameraSet, 8'd0, 16'd0, 4'hF, 16'h1234, 4'd0, 16'hFFFF));
        n_total++;
        if (camera_out !== exp)
            $display("FAIL camera_unknown_prop: camera=%h want %h", camera_out, exp);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        inst_in = mk(opCameraSet, 8'd0, 16'd0, cpYLocation, 16'h1111, 4'd0, 16'd0);
        inst_valid_in = 1'b1;
        tick();
        n_total++;
        if (camera_out.yloc !== 16'h1111 || inst_ready_out !== 1'b1)
            $display("FAIL b2b_first: yloc=%h ready=%b, want 1111 1", camera_out.yloc, inst_ready_out);
        else n_pass++;
        inst_in = mk(opCameraSet, 8'd0, 16'd0, cpZLocation, 16'h2222, 4'd0, 16'd0);
        tick();
        inst_valid_in = 1'b0;
        n_total++;
        if (camera_out.yloc !== 16'h1111 || camera_out.zloc !== 16'h2222)
            $display("FAIL b2b_second: yloc=%h zloc=%h, want 1111 2222", camera_out.yloc, camera_out.zloc);
        else n_pass++;
    endtask

    task automatic test_light_rmw();
        Light init;
        Light exp;
        int   cnt0;
        init = '{lType: 2'd2, col: 16'h1111, xloc: 16'h0102, yloc: 16'h0304,
                 zloc: 16'h0506, intensity: 16'h0708};
        exp  = '{lType: 2'd2, col: 16'hF800, xloc: 16'h0102, yloc: 16'h0304,
                 zloc: 16'h0506, intensity: 16'h0708};
        preload_light(3'd3, init);
        cnt0 = light_we_cnt;
        send(mk(opLightSet, 8'd3, 16'd0, lpColor, 16'hF800, 4'd0, 16'd0));
        n_total++;
        if (light_addr_out !== 3'd3 || light_we_out !== 1'b0 || inst_ready_out !== 1'b0)
            $display("FAIL light_rd: addr=%0d we=%b ready=%b, want 3 0 0",
                     light_addr_out, light_we_out, inst_ready_out);
        else n_pass++;
        tick();
        n_total++;
        if (light_addr_out !== 3'd3 || light_we_out !== 1'b0)
            $display("FAIL light_wait: addr=%0d we=%b, want 3 0", light_addr_out, light_we_out);
        else n_pass++;
        tick();
        n_total++;
        if (light_we_out !== 1'b1 || light_addr_out !== 3'd3)
            $display("FAIL light_wr_strobe: we=%b addr=%0d, want 1 3", light_we_out, light_addr_out);
        else n_pass++;
        n_total++;
        if (light_wdata_out !== exp)
            $display("FAIL light_wr_data: got %h want %h", light_wdata_out, exp);
        else n_pass++;
        tick();
        n_total++;
        if (inst_ready_out !== 1'b1 || light_we_out !== 1'b0 || light_we_cnt - cnt0 !== 1)
            $display("FAIL light_done: ready=%b we=%b writes=%0d, want 1 0 1",
                     inst_ready_out, light_we_out, light_we_cnt - cnt0);
        else n_pass++;
        n_total++;
        if (light_mem[3] !== exp)
            $display("FAIL light_mem: got %h want %h", light_mem[3], exp);
        else n_pass++;

        // Highest valid index, two updates in one instruction.
        init = '{lType: 2'd1, col: 16'hAAAA, xloc: 16'h0001, yloc: 16'h0002,
                 zloc: 16'h0003, intensity: 16'h0004};
        exp  = '{lType: 2'd3, col: 16'hAAAA, xloc: 16'h0001, yloc: 16'h0002,
                 zloc: 16'h0003, intensity: 16'h5555};
        preload_light(3'd7, init);
        send(mk(opLightSet, 8'd7, 16'd0, lpType, 16'h0003, lpIntensity, 16'h5555));
        tick();
        tick();
        n_total++;
        if (light_we_out !== 1'b1 || light_wdata_out !== exp)
            $display("FAIL light_two_props: we=%b data=%h, want 1 %h", light_we_out, light_wdata_out, exp);
        else n_pass++;
        tick();
    endtask

    task automatic test_light_err();
        int cnt0;
        cnt0 = light_we_cnt;
        send(mk(opLightSet, 8'd9, 16'd0, lpColor, 16'h1234, 4'd0, 16'd0));
        n_total++;
        if (err_out !== 1'b1 || inst_ready_out !== 1'b1 || light_we_out !== 1'b0)
            $display("FAIL light_idx9_err: err=%b ready=%b we=%b, want 1 1 0",
                     err_out, inst_ready_out, light_we_out);
        else n_pass++;
        tick();
        n_total++;
        if (err_out !== 1'b0)
            $display("FAIL err_pulse_width: err=%b want 0", err_out);
        else n_pass++;
        send(mk(opLightSet, 8'd8, 16'd0, lpColor, 16'h1234, 4'd0, 16'd0));
        n_total++;
        if (err_out !== 1'b1)
            $display("FAIL light_idx8_err: err=%b want 1", err_out);
        else n_pass++;
        tick();
        tick();
        tick();
        n_total++;
        if (light_we_cnt !== cnt0)
            $display("FAIL light_err_no_write: writes=%0d want %0d", light_we_cnt, cnt0);
        else n_pass++;
    endtask

    task automatic test_geom();
        Triangle init;
        Triangle exp;
        int      cnt0;
        init = '{mat: 2'd1, col: 16'h2222, x1: 16'h0011, y1: 16'h0022, x2: 16'h0033,
                 y2: 16'h0044, x3: 16'h0055, y3: 16'h0066};
        exp  = '{mat: 2'd1, col: 16'h2222, x1: 16'h3C00, y1: 16'h0022, x2: 16'h0033,
                 y2: 16'h0044, x3: 16'h0055, y3: 16'h0066};
        preload_geom(10'd5, init);
        send(mk(opShapeData, 8'd0, 16'd5, tpX1, 16'h3C00, 4'd0, 16'd0));
        n_total++;
        if (geom_addr_out !== 10'd5 || geom_we_out !== 1'b0)
            $display("FAIL geom_rd: addr=%0d we=%b, want 5 0", geom_addr_out, geom_we_out);
        else n_pass++;
        tick();
        tick();
        n_total++;
        if (geom_we_out !== 1'b1 || geom_wdata_out !== exp || geom_addr_out !== 10'd5)
            $display("FAIL geom_wr: we=%b addr=%0d data=%h, want 1 5 %h",
                     geom_we_out, geom_addr_out, geom_wdata_out, exp);
        else n_pass++;
        tick();
        cnt0 = geom_we_cnt;
        send(mk(opShapeData, 8'd0, 16'd2000, tpX1, 16'h3C00, 4'd0, 16'd0));
        n_total++;
        if (err_out !== 1'b1 || inst_ready_out !== 1'b1)
            $display("FAIL geom_idx2000_err: err=%b ready=%b, want 1 1", err_out, inst_ready_out);
        else n_pass++;
        tick();
        send(mk(opShapeData, 8'd0, 16'd1024, tpX1, 16'h3C00, 4'd0, 16'd0));
        n_total++;
        if (err_out !== 1'b1)
            $display("FAIL geom_idx1024_err: err=%b want 1", err_out);
        else n_pass++;
        tick();
        // Shape map in a rasterization build is a mode mismatch.
        send(mk(opShapeSet, 8'd0, 16'd5, spColor, 16'h7777, 4'd0, 16'd0));
        n_total++;
        if (err_out !== 1'b1 || inst_ready_out !== 1'b1)
            $display("FAIL geom_mode_err: err=%b ready=%b, want 1 1", err_out, inst_ready_out);
        else n_pass++;
        tick();
        tick();
        tick();
        n_total++;
        if (geom_we_cnt !== cnt0)
            $display("FAIL geom_err_no_write: writes=%0d want %0d", geom_we_cnt, cnt0);
        else n_pass++;

        preload_geom(10'd4, init);
        send(mk(opShapeInit, 8'd0, 16'd4, 4'd0, 16'd0, 4'd0, 16'd0));
        n_total++;
        if (geom_we_out !== 1'b1 || geom_addr_out !== 10'd4 || geom_wdata_out !== '0)
            $display("FAIL shape_init_wr: we=%b addr=%0d data=%h, want 1 4 0",
                     geom_we_out, geom_addr_out, geom_wdata_out);
        else n_pass++;
        tick();
        n_total++;
        if (geom_we_out !== 1'b0 || inst_ready_out !== 1'b1 || geom_mem[4] !== '0)
            $display("FAIL shape_init_done: we=%b ready=%b mem=%h, want 0 1 0",
                     geom_we_out, inst_ready_out, geom_mem[4]);
        else n_pass++;
    endtask

    task automatic test_frame_loop();
        send(mk(opFrame, 8'd0, 16'd0, 4'd0, 16'd0, 4'd0, 16'd0));
        n_total++;
        if ({frame_out, loop_out, err_out} !== 3'b100 || inst_ready_out !== 1'b1)
            $display("FAIL frame_pulse: f/l/e=%b%b%b ready=%b, want 100 1",
                     frame_out, loop_out, err_out, inst_ready_out);
        else n_pass++;
        tick();
        n_total++;
        if (frame_out !== 1'b0)
            $display("FAIL frame_width: frame=%b want 0", frame_out);
        else n_pass++;
        send(mk(opLoop, 8'd0, 16'd0, 4'd0, 16'd0, 4'd0, 16'd0));
        n_total++;
        if ({frame_out, loop_out, err_out} !== 3'b010)
            $display("FAIL loop_pulse: f/l/e=%b%b%b want 010", frame_out, loop_out, err_out);
        else n_pass++;
        tick();
        send(mk(opUnsupported, 8'd0, 16'd0, 4'd0, 16'd0, 4'd0, 16'd0));
        n_total++;
        if ({frame_out, loop_out, err_out} !== 3'b001 || inst_ready_out !== 1'b1)
            $display("FAIL unsupported_err: f/l/e=%b%b%b ready=%b, want 001 1",
                     frame_out, loop_out, err_out, inst_ready_out);
        else n_pass++;
        tick();
    endtask

    task automatic test_render();
        int low_cnt;
        // Done outside RENDER_WAIT has no effect.
        render_done_in = 1'b1;
        tick();
        render_done_in = 1'b0;
        n_total++;
        if (inst_ready_out !== 1'b1 || render_start_out !== 1'b0)
            $display("FAIL stray_done: ready=%b start=%b, want 1 0", inst_ready_out, render_start_out);
        else n_pass++;
        send(mk(opRender, 8'd0, 16'd0, 4'd0, 16'd0, 4'd0, 16'd0));
        n_total++;
        if (render_start_out !== 1'b1)
            $display("FAIL render_start: got %b want 1", render_start_out);
        else n_pass++;
        low_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (inst_ready_out === 1'b0) low_cnt++;
            if (k < 9) tick();
        end
        n_total++;
        if (low_cnt !== 10 || render_start_out !== 1'b0)
            $display("FAIL render_wait: ready-low cycles=%0d start=%b, want 10 0",
                     low_cnt, render_start_out);
        else n_pass++;
        render_done_in = 1'b1;
        tick();
        render_done_in = 1'b0;
        n_total++;
        if (inst_ready_out !== 1'b1)
            $display("FAIL render_done: ready=%b want 1", inst_ready_out);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cnt0;
        cnt0 = light_we_cnt;
        send(mk(opLightSet, 8'd2, 16'd0, lpColor, 16'h00FF, 4'd0, 16'd0));
        tick();
        n_total++;
        if (inst_ready_out !== 1'b0 || light_addr_out !== 3'd2)
            $display("FAIL rmw_in_wait: ready=%b addr=%0d, want 0 2", inst_ready_out, light_addr_out);
        else n_pass++;
        #2 rst_in = 1'b1;
        #1;
        n_total++;
        if (camera_out !== '0 || light_we_out !== 1'b0 || light_addr_out !== '0 ||
            light_wdata_out !== '0 || err_out !== 1'b0 || halted_out !== 1'b0)
            $display("FAIL reset_mid_outputs: cam=%h we=%b addr=%0d wd=%h err=%b halt=%b, want 0",
                     camera_out, light_we_out, light_addr_out, light_wdata_out, err_out, halted_out);
        else n_pass++;
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        tick();
        n_total++;
        if (inst_ready_out !== 1'b1 || light_we_cnt !== cnt0)
            $display("FAIL reset_mid_release: ready=%b writes=%0d, want 1 %0d",
                     inst_ready_out, light_we_cnt, cnt0);
        else n_pass++;
    endtask

    task automatic test_end();
        send(mk(opEnd, 8'd0, 16'd0, 4'd0, 16'd0, 4'd0, 16'd0));
        n_total++;
        if (halted_out !== 1'b1 || inst_ready_out !== 1'b0)
            $display("FAIL end_halt: halted=%b ready=%b, want 1 0", halted_out, inst_ready_out);
        else n_pass++;
        inst_in = mk(opFrame, 8'd0, 16'd0, 4'd0, 16'd0, 4'd0, 16'd0);
        inst_valid_in = 1'b1;
        tick();
        tick();
        inst_valid_in = 1'b0;
        n_total++;
        if (halted_out !== 1'b1 || inst_ready_out !== 1'b0 || frame_out !== 1'b0)
            $display("FAIL end_sticky: halted=%b ready=%b frame=%b, want 1 0 0",
                     halted_out, inst_ready_out, frame_out);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_camera();
        test_back_to_back();
        test_light_rmw();
        test_light_err();
        test_geom();
        test_frame_loop();
        test_render();
        test_reset_mid();
        test_end();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
